hazard_detect: RTL and testbench

//  Producer of the Hazard bubble request consumed by the ID/EX control-zeroing mux.
//  - Detects load-use RAW hazards between the ID and EX stages.
//  - Tracks the multi-cycle mult/div unit and stalls HI/LO readers and writers until it is idle.
//  - Drives Hazard, PCWrite and IFIDWrite so the front end freezes while a bubble is injected.

---
 rtl/hazard_detect_pkg.sv | 28 ++
 rtl/hazard_muldiv_timer.sv | 76 +++++++
 rtl/hazard_detect.sv | 85 ++++++++
 tb/tb_hazard_detect.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/hazard_detect_pkg.sv
// ---------------------------------------------------------------------------
// hazard_detect_pkg
//   Definitions shared by the hazard unit and the control decoder:
//   - hz_state_t      : encoding of the mult/div tracker state
//   - MULDIV_LAT_DEF  : default number of cycles from a mult/div entering EX
//                       until HI/LO holds a valid result
//   - CNT_W_DEF       : default width of the mult/div countdown counter
//   - MEMREAD_NONE    : MemRead code for "not a load" (same code the control
//                       decoder emits)
// ---------------------------------------------------------------------------
package hazard_detect_pkg;

  typedef enum logic {
    HZ_IDLE = 1'b0,
    HZ_BUSY = 1'b1
  } hz_state_t;

  localparam int MULDIV_LAT_DEF = 4;
  localparam int CNT_W_DEF      = 3;

  localparam logic [1:0] MEMREAD_NONE = 2'b00;

  // Value loaded into the countdown so that busy lasts exactly lat cycles.
  function automatic int muldiv_reload(input int lat);
    return lat - 1;
  endfunction

endpackage : hazard_detect_pkg

// File: rtl/hazard_muldiv_timer.sv
// ---------------------------------------------------------------------------
// hazard_muldiv_timer
//   Tracks the multi-cycle mult/div unit. A start pulse puts the tracker in
//   BUSY for exactly MULDIV_LAT cycles; busy is a pure function of the state
//   register, so start never reaches busy combinationally.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   HZ_IDLE | no mult/div in flight, HI/LO valid
//   HZ_BUSY | mult/div in flight, counter holds remaining busy cycles - 1
//
// Ports
//   clk    in  1  pipeline clock, rising edge
//   rst    in  1  synchronous reset, active-high
//   start  in  1  mult/div entering EX this cycle
//   busy   out 1  HI/LO result not yet valid
// ---------------------------------------------------------------------------
module hazard_muldiv_timer
  import hazard_detect_pkg::*;
#(
  parameter int MULDIV_LAT = MULDIV_LAT_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(muldiv_reload(MULDIV_LAT));
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  hz_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HZ_IDLE;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      HZ_IDLE: begin
        if (start) begin
          state_d = HZ_BUSY;
          cnt_d   = RELOAD;
        end
      end
      HZ_BUSY: begin
        // A second start while busy restarts the full latency window.
        if (start) begin
          cnt_d = RELOAD;
        end else if (cnt_q == CNT_ZERO) begin
          state_d = HZ_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = HZ_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  assign busy = (state_q == HZ_BUSY);

endmodule : hazard_muldiv_timer

// File: rtl/hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
//   Produces the bubble request for the ID/EX control-zeroing mux and freezes
//   the front end while the bubble is injected.
//   - Load-use RAW hazard between the load in EX and the instruction in ID.
//   - HI/LO readers and writers in ID wait while the mult/div unit is busy.
//
// Ports
//   clk          in  1  pipeline clock, rising edge
//   rst          in  1  synchronous reset, active-high
//   IDRs         in  5  rs field of instruction in ID
//   IDRt         in  5  rt field of instruction in ID
//   IDUsesRt     in  1  ID instruction reads rt as a source
//   IDHiLoRead   in  1  ID instruction is mfhi/mflo
//   IDHiLoWrite  in  1  ID instruction is mult/div/mthi/mtlo
//   EXMemRead    in  2  EX-stage MemRead encoding; non-zero = load
//   EXWriteReg   in  5  destination register of EX instruction
//   EXHiLoWrite  in  1  EX instruction starts a mult/div
//   Hazard       out 1  1 = bubble into ID/EX
//   PCWrite      out 1  0 = hold PC
//   IFIDWrite    out 1  0 = hold IF/ID register
//   MulDivBusy   out 1  mult/div result not yet valid
// ---------------------------------------------------------------------------
module hazard_detect
  import hazard_detect_pkg::*;
#(
  parameter int MULDIV_LAT = MULDIV_LAT_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] IDRs,
  input  logic [4:0] IDRt,
  input  logic       IDUsesRt,
  input  logic       IDHiLoRead,
  input  logic       IDHiLoWrite,
  input  logic [1:0] EXMemRead,
  input  logic [4:0] EXWriteReg,
  input  logic       EXHiLoWrite,
  output logic       Hazard,
  output logic       PCWrite,
  output logic       IFIDWrite,
  output logic       MulDivBusy
);

  logic ex_is_load;
  logic ex_dest_live;
  logic rs_match;
  logic rt_match;
  logic lu;
  logic md;
  logic busy;
  logic stall;

  hazard_muldiv_timer #(
    .MULDIV_LAT (MULDIV_LAT),
    .CNT_W      (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .start (EXHiLoWrite),
    .busy  (busy)
  );

  // $0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign ex_is_load   = (EXMemRead != MEMREAD_NONE);
  assign ex_dest_live = (EXWriteReg != 5'd0);
  assign rs_match     = (EXWriteReg == IDRs);
  assign rt_match     = IDUsesRt && (EXWriteReg == IDRt);

  // One bubble suffices: the next cycle the load has moved on to MEM.
  assign lu = ex_is_load && ex_dest_live && (rs_match || rt_match);

  assign md = busy && (IDHiLoRead || IDHiLoWrite);

  assign stall = lu || md;

  // Outputs are held at their inactive values for the whole reset cycle,
  // independent of whatever the pipeline inputs are doing.
  assign Hazard     = stall && !rst;
  assign PCWrite    = !Hazard;
  assign IFIDWrite  = !Hazard;
  assign MulDivBusy = busy && !rst;

endmodule : hazard_detect

// File: tb/tb_hazard_detect.sv
module tb_hazard_detect;

  logic       clk;
  logic       rst;
  logic [4:0] IDRs;
  logic [4:0] IDRt;
  logic       IDUsesRt;
  logic       IDHiLoRead;
  logic       IDHiLoWrite;
  logic [1:0] EXMemRead;
  logic [4:0] EXWriteReg;
  logic       EXHiLoWrite;
  logic       Hazard;
  logic       PCWrite;
  logic       IFIDWrite;
  logic       MulDivBusy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] exp_q[$];
  string      name_q[$];
  logic       drv_done = 1'b0;

  hazard_detect #(
    .MULDIV_LAT (4),
    .CNT_W      (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .IDRs        (IDRs),
    .IDRt        (IDRt),
    .IDUsesRt    (IDUsesRt),
    .IDHiLoRead  (IDHiLoRead),
    .IDHiLoWrite (IDHiLoWrite),
    .EXMemRead   (EXMemRead),
    .EXWriteReg  (EXWriteReg),
    .EXHiLoWrite (EXHiLoWrite),
    .Hazard      (Hazard),
    .PCWrite     (PCWrite),
    .IFIDWrite   (IFIDWrite),
    .MulDivBusy  (MulDivBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs just after the rising edge and queue the
  // expected {Hazard, PCWrite, IFIDWrite, MulDivBusy} for that cycle.
  task automatic step(input string nm, input logic r,
                      input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                      input logic hr, input logic hw,
                      input logic [1:0] mr, input logic [4:0] wr, input logic exh,
                      input logic eh, input logic eb);
    @(posedge clk);
    #1;
    rst         = r;
    IDRs        = rs;
    IDRt        = rt;
    IDUsesRt    = ur;
    IDHiLoRead  = hr;
    IDHiLoWrite = hw;
    EXMemRead   = mr;
    EXWriteReg  = wr;
    EXHiLoWrite = exh;
    exp_q.push_back({eh, ~eh, ~eh, eb});
    name_q.push_back(nm);
  endtask

  task automatic idle(input string nm, input logic eb);
    step(nm, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 1'b0, 1'b0, eb);
  endtask

  // Monitor: every falling edge with a pending expectation is compared.
  initial begin
    logic [3:0] e;
    logic [3:0] a;
    string      nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = {Hazard, PCWrite, IFIDWrite, MulDivBusy};
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL %s: got Hazard/PCWrite/IFIDWrite/MulDivBusy=%b, expected %b", nm, a, e);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; IDRs = '0; IDRt = '0; IDUsesRt = 1'b0; IDHiLoRead = 1'b0;
    IDHiLoWrite = 1'b0; EXMemRead = '0; EXWriteReg = '0; EXHiLoWrite = 1'b0;

    // Reset with random inputs, then with a forced load-use match and a mult start.
    for (int i = 0; i < 2; i++) begin
      step("reset_random", 1'b1, 5'($urandom), 5'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), 2'($urandom), 5'($urandom), 1'($urandom),
           1'b0, 1'b0);
    end
    step("reset_forced", 1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 2'b01, 5'd8, 1'b1, 1'b0, 1'b0);
    idle("after_reset", 1'b0);

    // Load-use on rs, then the load has left EX.
    step("lu_rs",       1'b0, 5'd8, 5'd3, 1'b0, 1'b0, 1'b0, 2'b01, 5'd8, 1'b0, 1'b1, 1'b0);
    step("lu_released", 1'b0, 5'd8, 5'd3, 1'b0, 1'b0, 1'b0, 2'b00, 5'd8, 1'b0, 1'b0, 1'b0);
    step("lu_rt",       1'b0, 5'd1, 5'd17, 1'b1, 1'b0, 1'b0, 2'b10, 5'd17, 1'b0, 1'b1, 1'b0);
    step("lu_rt_mr11",  1'b0, 5'd31, 5'd31, 1'b1, 1'b0, 1'b0, 2'b11, 5'd31, 1'b0, 1'b1, 1'b0);
    // Boundary: $0 and unused rt.
    step("lu_r0",       1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
    step("rt_unused",   1'b0, 5'd4, 5'd9, 1'b0, 1'b0, 1'b0, 2'b01, 5'd9, 1'b0, 1'b0, 1'b0);
    step("no_match",    1'b0, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0, 2'b01, 5'd6, 1'b0, 1'b0, 1'b0);
    step("nonload",     1'b0, 5'd6, 5'd6, 1'b1, 1'b0, 1'b0, 2'b00, 5'd6, 1'b0, 1'b0, 1'b0);

    // Mult at t with mfhi held in ID: stall t+1..t+4, released t+5.
    step("md_start",    1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 2'b00, 5'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      step("md_stall",  1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 2'b00, 5'd0, 1'b0, 1'b1, 1'b1);
    step("md_release",  1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);

    // Busy but ID does not touch HI/LO: no bubble.
    step("md_start2",   1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) idle("busy_no_hilo", 1'b1);
    idle("busy_cleared", 1'b0);

    // Load-use and md together give one Hazard; busy still ends at t+5.
    step("both_start",  1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 1'b1, 1'b0, 1'b0);
    step("both_stall",  1'b0, 5'd12, 5'd0, 1'b0, 1'b1, 1'b0, 2'b01, 5'd12, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++)
      step("mtlo_stall", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd0, 1'b0, 1'b1, 1'b1);
    step("both_release", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);

    // Reset at t+2 drops the stall; a new mult restarts the full count.
    step("rst_start",   1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 2'b00, 5'd0, 1'b1, 1'b0, 1'b0);
    step("rst_busy",    1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 2'b00, 5'd0, 1'b0, 1'b1, 1'b1);
    step("rst_mid",     1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    step("rst_after",   1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    step("restart",     1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 2'b00, 5'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      step("restart_stall", 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 2'b00, 5'd0, 1'b0, 1'b1, 1'b1);
    step("restart_release", 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);

    // Second start while busy reloads the count: busy for 4 cycles after the retrigger.
    step("retrig_a",    1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 1'b1, 1'b0, 1'b0);
    step("retrig_b",    1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) idle("retrig_busy", 1'b1);
    idle("retrig_idle", 1'b0);

    drv_done = 1'b1;
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_hazard_detect
